// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Walks every input vector of an external N_IN-input boolean unit in
// ascending order. Each vector is held for SETTLE_CYCLES cycles and then
// sampled, which builds a captured truth table. That table is compared
// entry by entry against an expected table that is latched at start.
// Results hold from the done pulse until the next accepted start or reset.
module truth_table_sweeper #(
    parameter int N_IN          = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [(1<<N_IN)-1:0] expected,
    output logic [N_IN-1:0]     f_in,
    input  logic                f_out,
    output logic                busy,
    output logic                done,
    output logic [(1<<N_IN)-1:0] table_out,
    output logic                match,
    output logic [N_IN:0]       err_count,
    output logic [N_IN-1:0]     first_err,
    output logic                first_err_valid
);

    localparam int              T        = 1 << N_IN;
    localparam logic [3:0]      SETTLE_W = 4'(SETTLE_CYCLES);
    localparam logic [N_IN-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Control state
    state_t          r_state;
    state_t          w_state_nxt;
    logic [N_IN-1:0] r_idx;
    logic [N_IN-1:0] w_idx_nxt;
    logic [3:0]      r_wait;
    logic [3:0]      w_wait_nxt;

    // Registered outputs and their next values
    logic            r_busy;
    logic            r_done;
    logic [N_IN-1:0] r_f_in;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic [N_IN-1:0] w_f_in_nxt;

    // Result datapath
    logic [T-1:0]    r_expected;
    logic [T-1:0]    r_table;
    logic [N_IN:0]   r_err_count;
    logic [N_IN-1:0] r_first_err;
    logic            r_first_err_valid;
    logic            r_match;

    logic            w_sample;
    logic            w_mismatch;
    logic [N_IN:0]   w_err_count_nxt;

    // A sample is taken on the last held cycle of a vector. An abort on that
    // same edge suppresses it.
    always_comb begin
        w_sample        = (r_state == ST_APPLY) && !abort && (r_wait == 4'd0);
        w_mismatch      = w_sample && (f_out != r_expected[r_idx]);
        w_err_count_nxt = r_err_count + (w_mismatch ? (N_IN+1)'(1) : (N_IN+1)'(0));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_wait  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // Next-state logic: sweep sequencing, settle countdown and abort handling
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wait_nxt  = r_wait;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_APPLY;
                    w_idx_nxt   = '0;
                    w_wait_nxt  = SETTLE_W;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_wait != 4'd0) begin
                    w_wait_nxt = r_wait - 4'd1;
                end else if (r_idx == IDX_LAST) begin
                    w_state_nxt = ST_FINISH;
                end else begin
                    w_idx_nxt  = r_idx + N_IN'(1);
                    w_wait_nxt = SETTLE_W;
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
                w_wait_nxt  = 4'd0;
            end
        endcase
    end

    // Output decode from the upcoming state, registered so that busy/done/f_in
    // line up with the state they describe
    always_comb begin
        w_busy_nxt = (w_state_nxt == ST_APPLY);
        w_done_nxt = (w_state_nxt == ST_FINISH);
        if (w_state_nxt == ST_APPLY) begin
            w_f_in_nxt = w_idx_nxt;
        end else begin
            w_f_in_nxt = '0;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_f_in <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_f_in <= w_f_in_nxt;
        end
    end

    // Result capture. Start clears the results and latches expected. Each
    // sample fills one table entry and updates the error bookkeeping. The
    // final sample also resolves match, so it is valid during the done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_expected        <= '0;
            r_table           <= '0;
            r_err_count       <= '0;
            r_first_err       <= '0;
            r_first_err_valid <= 1'b0;
            r_match           <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_expected        <= expected;
            r_table           <= '0;
            r_err_count       <= '0;
            r_first_err       <= '0;
            r_first_err_valid <= 1'b0;
            r_match           <= 1'b0;
        end else if (w_sample) begin
            r_table[r_idx] <= f_out;
            r_err_count    <= w_err_count_nxt;
            if (w_mismatch && !r_first_err_valid) begin
                r_first_err       <= r_idx;
                r_first_err_valid <= 1'b1;
            end
            if (r_idx == IDX_LAST) begin
                r_match <= (w_err_count_nxt == '0);
            end
        end
    end

    assign f_in            = r_f_in;
    assign busy            = r_busy;
    assign done            = r_done;
    assign table_out       = r_table;
    assign match           = r_match;
    assign err_count       = r_err_count;
    assign first_err       = r_first_err;
    assign first_err_valid = r_first_err_valid;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper. It uses a default build (SETTLE_CYCLES=1)
// driven from a vector table through a scoreboard queue. A SETTLE_CYCLES=0
// build covers the ignored-restart case. Hand-written sequences cover the
// abort and asynchronous reset cases.
module tb_truth_table_sweeper;

    localparam int N_IN = 4;
    localparam int T    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start, abort;
    logic [T-1:0]  expected;
    logic [N_IN-1:0] f_in;
    logic          f_out;
    logic          busy, done, match, fev;
    logic [T-1:0]  table_out;
    logic [N_IN:0] err_count;
    logic [N_IN-1:0] first_err;
    logic [2:0]    sel;

    logic          start0, abort0;
    logic [T-1:0]  expected0;
    logic [N_IN-1:0] f_in0;
    logic          f_out0;
    logic          busy0, done0, match0, fev0;
    logic [T-1:0]  table_out0;
    logic [N_IN:0] err_count0;
    logic [N_IN-1:0] first_err0;
    logic [2:0]    sel0;

    int checks = 0;
    int errors = 0;

    // Reference boolean functions driven onto f_out
    function automatic logic fmodel(input logic [2:0] s, input logic [3:0] x);
        case (s)
            3'd0:    fmodel = 1'b1;
            3'd1:    fmodel = ^x;
            3'd2:    fmodel = x[3] & x[2];
            3'd3:    fmodel = 1'b0;
            3'd4:    fmodel = x[0];
            default: fmodel = 1'b0;
        endcase
    endfunction

    assign f_out  = fmodel(sel, f_in);
    assign f_out0 = fmodel(sel0, f_in0);

    truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .expected(expected),
        .f_in(f_in), .f_out(f_out), .busy(busy), .done(done), .table_out(table_out),
        .match(match), .err_count(err_count), .first_err(first_err),
        .first_err_valid(fev)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .expected(expected0),
        .f_in(f_in0), .f_out(f_out0), .busy(busy0), .done(done0), .table_out(table_out0),
        .match(match0), .err_count(err_count0), .first_err(first_err0),
        .first_err_valid(fev0)
    );

    typedef struct {
        logic [2:0]      sel;
        logic [T-1:0]    exp_in;
        logic [T-1:0]    tbl;
        logic            m;
        logic [N_IN:0]   ec;
        logic [N_IN-1:0] fe;
        logic            fev;
    } vec_t;

    vec_t vecs[7];
    vec_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One full sweep on the default build, with timing and result checks
    task automatic run_sweep(input vec_t v);
        vec_t e;
        int   c, busy_n, done_c;
        bit   fin_ok;
        @(negedge clk);
        sel      = v.sel;
        expected = v.exp_in;
        start    = 1'b1;
        sb_q.push_back(v);
        @(negedge clk);
        start    = 1'b0;
        expected = ~v.exp_in;
        c = 1; busy_n = 0; done_c = 0; fin_ok = 1'b1;
        while (done_c == 0 && c <= 100) begin
            if (busy) begin
                busy_n++;
                if (f_in != 4'((c - 1) / 2)) fin_ok = 1'b0;
            end
            if (done) begin
                done_c = c;
            end else begin
                @(negedge clk);
                c++;
            end
        end
        check("done_cycle", done_c, 33);
        check("busy_cycles", busy_n, 32);
        check("f_in_steps", 32'(fin_ok), 1);
        e = sb_q.pop_front();
        check("table_out", table_out, e.tbl);
        check("match", match, e.m);
        check("err_count", err_count, e.ec);
        check("first_err", first_err, e.fe);
        check("first_err_valid", fev, e.fev);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
        check("idle_f_in", f_in, 0);
        check("hold_table", table_out, e.tbl);
        check("hold_match", match, e.m);
    endtask

    initial begin
        int c, dseen;
        vecs[0] = '{3'd0, 16'hFFFF, 16'hFFFF, 1'b1, 5'd0,  4'd0,  1'b0};
        vecs[1] = '{3'd1, 16'h6996, 16'h6996, 1'b1, 5'd0,  4'd0,  1'b0};
        vecs[2] = '{3'd2, 16'hFFFF, 16'hF000, 1'b0, 5'd12, 4'd0,  1'b1};
        vecs[3] = '{3'd3, 16'h0001, 16'h0000, 1'b0, 5'd1,  4'd0,  1'b1};
        vecs[4] = '{3'd2, 16'h0000, 16'hF000, 1'b0, 5'd4,  4'd12, 1'b1};
        vecs[5] = '{3'd1, 16'h7996, 16'h6996, 1'b0, 5'd1,  4'd12, 1'b1};
        vecs[6] = '{3'd4, 16'hAAAA, 16'hAAAA, 1'b1, 5'd0,  4'd0,  1'b1 & 1'b0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; expected = '0; sel = 3'd0;
        start0 = 1'b0; abort0 = 1'b0; expected0 = '0; sel0 = 3'd0;
        #1;
        check("reset_outputs", {28'd0, busy, done, match, fev}, 0);
        check("reset_table", table_out, 0);
        check("reset_counts", {err_count, first_err, f_in}, 0);
        check("reset_dut0", {busy0, done0, match0, fev0, f_in0, table_out0, err_count0}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven sweeps
        for (int i = 0; i < 7; i++) run_sweep(vecs[i]);

        // Abort in cycle 10: samples for vectors 0..3 are kept, no done pulse
        @(negedge clk);
        sel = 3'd1; expected = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_match", match, 0);
        check("abort_f_in", f_in, 0);
        check("abort_table", table_out, 16'h0006);
        check("abort_err_count", err_count, 2);
        check("abort_first_err", {fev, first_err}, {1'b1, 4'd1});
        dseen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dseen++;
        end
        check("abort_no_done", dseen, 0);
        run_sweep(vecs[1]);

        // Asynchronous reset in the middle of a sweep
        @(negedge clk);
        sel = 3'd2; expected = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_reset_err", err_count, 5);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_all",
              {busy, done, match, fev, f_in, first_err, err_count, table_out}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {busy, done, f_in}, 0);
        run_sweep(vecs[2]);

        // SETTLE_CYCLES=0 build: restart in cycle 5 ignored, expected change ignored
        @(negedge clk);
        sel0 = 3'd1; expected0 = 16'h6996; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        c = 1;
        repeat (4) begin
            @(negedge clk);
            c++;
        end
        start0 = 1'b1; expected0 = 16'h0000;
        @(negedge clk);
        c++;
        start0 = 1'b0;
        while (!done0 && c < 60) begin
            @(negedge clk);
            c++;
        end
        check("s0_done_cycle", c, 17);
        check("s0_table", table_out0, 16'h6996);
        check("s0_match", match0, 1);
        check("s0_err_count", err_count0, 0);
        @(negedge clk);
        check("s0_idle", {busy0, done0, f_in0}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequencer that exhaustively exercises an external N-input, 1-output combinational boolean unit. It drives every input vector in ascending order and waits a programmable settle time. It then samples the unit's output into a truth-table register and compares the result against an expected table. It sits between a boolean function block and the control or self-check logic, replacing a hand-written sweep loop.

Parameters:
N_IN, 4, number of function inputs (legal 1..6); table width T = 2**N_IN
SETTLE_CYCLES, 1, cycles each vector is held before sampling (legal 0..15)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
start  input  1  begin sweep; accepted only in IDLE
abort  input  1  synchronous abort of a running sweep
expected  input  T  expected truth table, bit i = expected f(i); latched when start is accepted
f_in  output  N_IN  vector to the function unit; MSB = first input (a), LSB = last (d)
f_out  input  1  function unit output, combinational from f_in
busy  output  1  high while sweeping
done  output  1  one-cycle pulse when the sweep completes
table_out  output  T  captured truth table, bit i = f_out sampled with f_in = i
match  output  1  table_out == latched expected; valid from the done cycle
err_count  output  N_IN+1  number of mismatching entries
first_err  output  N_IN  lowest mismatching index
first_err_valid  output  1  at least one mismatch recorded

Behaviour:
- Reset, asynchronous, effective immediately and at any time including mid-sweep:
  - state = IDLE.
  - f_in, table_out, err_count, first_err = 0.
  - busy, done, match, first_err_valid = 0.
  - Latched expected = 0.
- States:
  - IDLE: f_in = 0, busy = 0. If start = 1 at the edge:
    - latch expected;
    - clear table_out, err_count, first_err, first_err_valid and match;
    - set idx = 0 and wait = SETTLE_CYCLES;
    - go to APPLY.
  - APPLY: busy = 1, f_in = idx.
    - If wait != 0: decrement wait.
    - If wait == 0: at that edge, table_out[idx] <= f_out. If f_out != expected[idx], increment err_count. If this is the first mismatch, also set first_err = idx and first_err_valid = 1.
    - After the sample, if idx == T-1 go to FINISH. Otherwise idx <= idx+1 and wait <= SETTLE_CYCLES.
  - FINISH, exactly one cycle:
    - busy = 0, done = 1, f_in = 0.
    - match = (err_count == 0), using the final count including the last sample.
    - Next state is IDLE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - Call the edge that accepts start edge 0. busy is high for T*(SETTLE_CYCLES+1) cycles, and done is high in the cycle after that.
  - Defaults: busy for 32 cycles, done in cycle 33.
- Results (table_out, match, err_count, first_err, first_err_valid) hold from FINISH until the next accepted start or reset.
- start while in APPLY or FINISH: ignored, with no restart and no effect on the latched expected.
- abort = 1 in APPLY:
  - go to IDLE at that edge, with no sample taken at that edge and no done pulse;
  - match stays 0; table_out and err state keep their partial values.
  - abort in IDLE or FINISH: no effect.
  - abort and start together in IDLE: start wins.
- Changes on the expected input after start is accepted do not affect the sweep.
- idx wraps only via FINISH. err_count saturation is not needed, since the maximum is T, which fits in N_IN+1 bits.

Test Plan:
- Constant-1 function (f_out = 1), expected = 16'hFFFF, defaults -> table_out = 16'hFFFF, match = 1, err_count = 0, first_err_valid = 0, done exactly in cycle 33, busy high in cycles 1..32.
- 4-input parity (f_out = ^f_in), expected = 16'h6996 -> table_out = 16'h6996, match = 1; f_in observed stepping 0..15 with each value held 2 cycles.
- f_out = a&b (f_in[3]&f_in[2]), expected = 16'hFFFF -> table_out = 16'hF000, match = 0, err_count = 12, first_err = 0, first_err_valid = 1.
- SETTLE_CYCLES = 0 build: start, then start pulsed again in cycle 5 and expected changed in cycle 5 -> restart ignored, original expected used, done in cycle 17.
- abort asserted in cycle 10 -> IDLE next cycle, busy = 0, no done pulse, match = 0. A new start then completes normally with correct results.
- rst asserted asynchronously mid-cycle during APPLY -> all outputs 0 immediately. After release, IDLE with f_in = 0, and the next start produces a full, correct sweep.
